// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: FSM state encoding and default baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx.sv
// 8N1/8N2 serial transmitter that pops words straight from a first-word-fall-through FIFO.
// tx and busy are registered from the next-state decode so the line never glitches.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IMAX = IW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] SMAX = SW'(STOP_BITS - 1);

  tx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [TW-1:0]         r_timer;
  logic [IW-1:0]         r_idx;
  logic [SW-1:0]         r_stop;
  logic                  r_tx;
  logic                  r_busy;

  tx_state_t             w_next;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [TW-1:0]         w_timer_next;
  logic [IW-1:0]         w_idx_next;
  logic [SW-1:0]         w_stop_next;
  logic                  w_tx_next;
  logic                  w_expire;
  logic                  w_last_stop;
  logic                  w_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    w_stop_next  = r_stop;
    w_expire     = (r_timer == TMAX);
    w_timer_next = w_expire ? '0 : r_timer + 1'b1;
    w_last_stop  = (r_state == STOP) && w_expire && (r_stop == SMAX);
    // Pop in IDLE or on the final stop cycle so back-to-back frames have no gap.
    w_rd         = !reset && !empty && ((r_state == IDLE) || w_last_stop);

    case (r_state)
      IDLE: begin
        w_timer_next = '0;
        if (w_rd) begin
          w_next       = START;
          w_shift_next = r_data;
        end
      end
      START: begin
        if (w_expire) begin
          w_next     = DATA;
          w_idx_next = '0;
        end
      end
      DATA: begin
        if (w_expire) begin
          w_shift_next = r_shift >> 1;
          w_idx_next   = r_idx + 1'b1;
          if (r_idx == IMAX) begin
            w_next      = STOP;
            w_stop_next = '0;
          end
        end
      end
      STOP: begin
        if (w_expire) begin
          w_stop_next = r_stop + 1'b1;
          if (w_last_stop) begin
            w_stop_next = '0;
            if (w_rd) begin
              w_next       = START;
              w_shift_next = r_data;
            end else begin
              w_next = IDLE;
            end
          end
        end
      end
      default: w_next = IDLE;
    endcase

    case (w_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_timer <= '0;
      r_idx   <= '0;
      r_stop  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_timer <= w_timer_next;
      r_idx   <= w_idx_next;
      r_stop  <= w_stop_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_next != IDLE);
    end
  end

  assign rd   = w_rd;
  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO and serial-line reference model, one instance per stop-bit setting.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int F1  = (1 + 8 + 1) * CPB;
  localparam int F2  = (1 + 8 + 2) * CPB;

  logic       clk;
  logic       reset;
  logic       empty1, empty2;
  logic [7:0] r_data1, r_data2;
  logic       rd1, rd2, tx1, tx2, busy1, busy2;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .empty(empty1), .r_data(r_data1),
    .rd(rd1), .tx(tx1), .busy(busy1)
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .empty(empty2), .r_data(r_data2),
    .rd(rd2), .tx(tx2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] fifo1[$];
  logic [7:0] fifo2[$];
  logic       line1[$];
  logic       line2[$];
  logic       hold1 = 1'b0;
  logic       hold2 = 1'b0;

  int obs_rd1, obs_busy1, obs_low1, obs_rd2, obs_busy2, obs_low2;
  int rd1_cyc[$];
  int rd2_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level at position pos of a frame: start bit, 8 data bits LSB first, then stop bits.
  function automatic logic frame_level(input logic [7:0] d, input int pos);
    int slot;
    slot = pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return 1'b1;
  endfunction

  task automatic drive();
    empty1  = hold1 || (fifo1.size() == 0);
    empty2  = hold2 || (fifo2.size() == 0);
    r_data1 = (fifo1.size() != 0) ? fifo1[0] : 8'($urandom);
    r_data2 = (fifo2.size() != 0) ? fifo2[0] : 8'($urandom);
  endtask

  task automatic clear_obs();
    obs_rd1 = 0; obs_busy1 = 0; obs_low1 = 0;
    obs_rd2 = 0; obs_busy2 = 0; obs_low2 = 0;
    rd1_cyc.delete();
    rd2_cyc.delete();
  endtask

  task automatic cycle();
    logic e1, e2;
    logic [7:0] d;
    @(negedge clk);
    e1 = !reset && !empty1 && (line1.size() <= 1);
    e2 = !reset && !empty2 && (line2.size() <= 1);
    check("rd1",   32'(rd1),   32'(e1));
    check("tx1",   32'(tx1),   32'((line1.size() != 0) ? line1[0] : 1'b1));
    check("busy1", 32'(busy1), 32'(line1.size() != 0));
    check("rd2",   32'(rd2),   32'(e2));
    check("tx2",   32'(tx2),   32'((line2.size() != 0) ? line2[0] : 1'b1));
    check("busy2", 32'(busy2), 32'(line2.size() != 0));
    if (rd1) begin obs_rd1++; rd1_cyc.push_back(cyc); end
    if (rd2) begin obs_rd2++; rd2_cyc.push_back(cyc); end
    if (busy1) obs_busy1++;
    if (busy2) obs_busy2++;
    if (!tx1) obs_low1++;
    if (!tx2) obs_low2++;
    @(posedge clk);
    cyc++;
    if (reset) begin
      line1.delete();
      line2.delete();
    end else begin
      if (line1.size() != 0) void'(line1.pop_front());
      if (line2.size() != 0) void'(line2.pop_front());
      if (e1) begin
        d = fifo1.pop_front();
        for (int k = 0; k < F1; k++) line1.push_back(frame_level(d, k));
      end
      if (e2) begin
        d = fifo2.pop_front();
        for (int k = 0; k < F2; k++) line2.push_back(frame_level(d, k));
      end
    end
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int diff;
    reset = 1'b1;
    fifo1.push_back(8'($urandom));
    drive();
    clear_obs();

    // 1: reset held with a word waiting, then exactly one pop on release
    run(5);
    check("t1_rd_in_reset", 32'(obs_rd1), 32'd0);
    reset = 1'b0;
    clear_obs();
    run(50);
    check("t1_pops", 32'(obs_rd1), 32'd1);
    check("t1_pop_first_cycle", 32'((rd1_cyc.size() != 0) ? rd1_cyc[0] : -1), 32'(cyc - 50));

    // 2: single 0xA5 frame
    fifo1.push_back(8'hA5);
    drive();
    clear_obs();
    run(50);
    check("t2_pops", 32'(obs_rd1), 32'd1);
    check("t2_busy_cycles", 32'(obs_busy1), 32'd40);
    check("t2_low_cycles", 32'(obs_low1), 32'd20);

    // 3: back-to-back 0xF0, 0xF1
    fifo1.push_back(8'hF0);
    fifo1.push_back(8'hF1);
    drive();
    clear_obs();
    run(90);
    check("t3_pops", 32'(obs_rd1), 32'd2);
    diff = (rd1_cyc.size() >= 2) ? rd1_cyc[1] - rd1_cyc[0] : -1;
    check("t3_pop_spacing", 32'(diff), 32'd40);
    check("t3_busy_cycles", 32'(obs_busy1), 32'd80);

    // 4: empty for 100 cycles
    clear_obs();
    run(100);
    check("t4_pops", 32'(obs_rd1 + obs_rd2), 32'd0);
    check("t4_busy", 32'(obs_busy1 + obs_busy2), 32'd0);

    // 5: asynchronous reset during data bit 3 of 0x55
    fifo1.push_back(8'h55);
    drive();
    clear_obs();
    run(19);
    fifo1.push_back(8'h3C);
    drive();
    #2;
    check("t5_tx_before_reset", 32'(tx1), 32'd0);
    reset = 1'b1;
    line1.delete();
    line2.delete();
    #1;
    check("t5_async_tx", 32'(tx1), 32'd1);
    check("t5_async_busy", 32'(busy1), 32'd0);
    check("t5_async_rd", 32'(rd1), 32'd0);
    run(3);
    reset = 1'b0;
    run(45);
    check("t5_pops", 32'(obs_rd1), 32'd2);

    // 6: two stop bits, 0x00 then 0xFF
    fifo2.push_back(8'h00);
    fifo2.push_back(8'hFF);
    drive();
    clear_obs();
    run(100);
    check("t6_pops", 32'(obs_rd2), 32'd2);
    diff = (rd2_cyc.size() >= 2) ? rd2_cyc[1] - rd2_cyc[0] : -1;
    check("t6_pop_spacing", 32'(diff), 32'd44);
    check("t6_low_cycles", 32'(obs_low2), 32'd40);
    check("t6_busy_cycles", 32'(obs_busy2), 32'd88);

    // random traffic with bursty FIFO availability
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0 && fifo1.size() < 4) fifo1.push_back(8'($urandom));
      if ($urandom_range(0, 15) == 0 && fifo2.size() < 4) fifo2.push_back(8'($urandom));
      hold1 = ($urandom_range(0, 3) == 0);
      hold2 = ($urandom_range(0, 3) == 0);
      drive();
      cycle();
    end
    hold1 = 1'b0;
    hold2 = 1'b0;
    drive();
    run(250);
    check("rand_drained1", 32'(fifo1.size() + line1.size()), 32'd0);
    check("rand_drained2", 32'(fifo2.size() + line2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
